// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-add/full-subtract cell plus a carry/borrow
// flop, consuming one operand bit per clock, LSB first, with start/busy/done handshake.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_step;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-2:0]   r_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cy;
  logic               r_mode;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_ovf;

  logic               w_ai;
  logic               w_bi;
  logic               w_sum;
  logic               w_cy_nxt;
  logic [WIDTH-1:0]   w_sh_full;

  // Single-bit full adder / full subtractor cell on the operand LSBs
  always_comb begin
    w_ai      = r_a[0];
    w_bi      = r_b[0];
    w_sum     = w_ai ^ w_bi ^ r_cy;
    if (r_mode) begin
      w_cy_nxt = (~w_ai & w_bi) | (r_cy & ~(w_ai ^ w_bi));
    end else begin
      w_cy_nxt = (w_ai & w_bi) | (r_cy & (w_ai ^ w_bi));
    end
    w_sh_full = {w_sum, r_sh};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial shifting and completion registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_cy     <= 1'b0;
      r_mode   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_a    <= a;
        r_b    <= b;
        r_sh   <= '0;
        r_cnt  <= '0;
        r_cy   <= cin;
        r_mode <= mode;
        r_busy <= 1'b1;
      end else if (w_step) begin
        r_a   <= {1'b0, r_a[WIDTH-1:1]};
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
        r_sh  <= w_sh_full[WIDTH-1:1];
        r_cnt <= r_cnt + CNT_W'(1);
        r_cy  <= w_cy_nxt;
        if (w_last) begin
          // Carry into the MSB differs from carry out of it on signed overflow
          r_result <= w_sh_full;
          r_cout   <= w_cy_nxt;
          r_ovf    <= r_cy ^ w_cy_nxt;
          r_busy   <= 1'b0;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub (WIDTH=8 and exhaustive WIDTH=2).
module tb_serial_add_sub;

  logic       clk;
  logic       rst_n;
  logic       start, mode, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, overflow;
  logic [7:0] result;

  logic       start2, mode2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, overflow2;
  logic [1:0] result2;

  int checks;
  int errors;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  serial_add_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .result(result2), .cout(cout2), .overflow(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one WIDTH=8 op, scramble inputs afterwards, and count edges until done
  task automatic run_op(input logic m, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, output logic [7:0] res, output logic co,
                        output logic ov, output int lat);
    @(negedge clk);
    start = 1'b1; mode = m; a = va; b = vb; cin = vc;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; a = ~va; b = 8'h55; cin = ~vc;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = result; co = cout; ov = overflow;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; mode2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    #3;
    checks++;
    if ({busy, done, result, cout, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_w8 busy=%b done=%b result=%h cout=%b ovf=%b expected all 0",
               busy, done, result, cout, overflow);
    end
    checks++;
    if ({busy2, done2, result2, cout2, overflow2} !== 6'h00) begin
      errors++;
      $display("FAIL reset_w2 busy=%b done=%b result=%h cout=%b ovf=%b expected all 0",
               busy2, done2, result2, cout2, overflow2);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [7:0] res; logic co, ov; int lat;
    run_op(1'b0, 8'h3C, 8'h5A, 1'b0, res, co, ov, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL add_latency got %0d expected 8", lat); end
    checks++;
    if ({res, co, ov} !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_3c_5a result=%h cout=%b ovf=%b expected 96 0 1", res, co, ov);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_done_width done=%b busy=%b expected 0 0 one cycle later", done, busy);
    end
  endtask

  task automatic test_sub();
    logic [7:0] res; logic co, ov; int lat;
    run_op(1'b1, 8'h10, 8'h20, 1'b0, res, co, ov, lat);
    checks++;
    if (lat !== 8 || {res, co, ov} !== {8'hF0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_10_20 lat=%0d result=%h cout=%b ovf=%b expected 8 f0 1 0",
               lat, res, co, ov);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] res; logic co, ov; int lat;
    run_op(1'b0, 8'hFF, 8'h00, 1'b1, res, co, ov, lat);
    checks++;
    if (lat !== 8 || {res, co, ov} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_ff_00_cin lat=%0d result=%h cout=%b ovf=%b expected 8 00 1 0",
               lat, res, co, ov);
    end
    run_op(1'b1, 8'h80, 8'h01, 1'b0, res, co, ov, lat);
    checks++;
    if (lat !== 8 || {res, co, ov} !== {8'h7F, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_80_01 lat=%0d result=%h cout=%b ovf=%b expected 8 7f 0 1",
               lat, res, co, ov);
    end
    run_op(1'b1, 8'h05, 8'h05, 1'b1, res, co, ov, lat);
    checks++;
    if (lat !== 8 || {res, co, ov} !== {8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_05_05_bin lat=%0d result=%h cout=%b ovf=%b expected 8 ff 1 0",
               lat, res, co, ov);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic seen_early;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h3C; b = 8'h5A; cin = 1'b0;
    @(posedge clk); #1;
    seen_early = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      start = (k == 3 || k == 7);
      a = 8'hFF; b = 8'hFF; mode = 1'b1; cin = 1'b1;
      @(posedge clk); #1;
      if (k < 8 && done === 1'b1) seen_early = 1'b1;
    end
    checks++;
    if (seen_early !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ignore early=%b done=%b busy=%b expected 0 1 0", seen_early, done, busy);
    end
    checks++;
    if ({result, cout, overflow} !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first result=%h cout=%b ovf=%b expected 96 0 1", result, cout, overflow);
    end
    start = 1'b1; mode = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept busy=%b done=%b expected 1 0", busy, done);
    end
    lat = -1;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat !== 9 || {result, cout, overflow} !== {8'hF0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second lat=%0d result=%h cout=%b ovf=%b expected 9 f0 1 0",
               lat, result, cout, overflow);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] res; logic co, ov; int lat;
    logic seen_done;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'hFF; b = 8'h01; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, cout, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL abort_reset busy=%b done=%b result=%h cout=%b ovf=%b expected all 0",
               busy, done, result, cout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h00) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet activity=%b expected 0 after aborted op", seen_done);
    end
    run_op(1'b0, 8'h01, 8'h01, 1'b0, res, co, ov, lat);
    checks++;
    if (lat !== 8 || {res, co, ov} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_recover lat=%0d result=%h cout=%b ovf=%b expected 8 02 0 0",
               lat, res, co, ov);
    end
  endtask

  task automatic test_exhaustive_w2();
    int ia, ib, sa, sb, full, sfull, lat;
    logic [1:0] eres;
    logic ec, eov;
    for (int m = 0; m < 2; m++) begin
      for (int va = 0; va < 4; va++) begin
        for (int vb = 0; vb < 4; vb++) begin
          for (int vc = 0; vc < 2; vc++) begin
            ia = va; ib = vb;
            sa = (va >= 2) ? va - 4 : va;
            sb = (vb >= 2) ? vb - 4 : vb;
            if (m == 0) begin
              full  = ia + ib + vc;
              sfull = sa + sb + vc;
              ec    = (full >= 4);
            end else begin
              full  = ia - ib - vc;
              sfull = sa - sb - vc;
              ec    = (full < 0);
            end
            eres = 2'(full & 3);
            eov  = (sfull > 1) || (sfull < -2);
            @(negedge clk);
            start2 = 1'b1; mode2 = 1'(m); a2 = 2'(va); b2 = 2'(vb); cin2 = 1'(vc);
            @(posedge clk); #1;
            start2 = 1'b0; a2 = ~2'(va); b2 = 2'(vb + 1); mode2 = ~1'(m); cin2 = ~1'(vc);
            lat = -1;
            for (int k = 1; k <= 10; k++) begin
              @(posedge clk); #1;
              if (done2 === 1'b1) begin lat = k; break; end
            end
            checks++;
            if (lat !== 2 || {result2, cout2, overflow2} !== {eres, ec, eov}) begin
              errors++;
              $display("FAIL w2 mode=%0d a=%0d b=%0d cin=%0d lat=%0d result=%0d cout=%b ovf=%b expected 2 %0d %b %b",
                       m, va, vb, vc, lat, result2, cout2, overflow2, eres, ec, eov);
            end
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_boundaries();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive_w2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
